// File: rtl/wb_crossbar_rr.sv
`default_nettype none
// wb_crossbar_rr: Wishbone classic crossbar, per-slave round-robin, cycle-level ownership,
// decode-miss and watchdog error termination.  Rev 1.0
module wb_crossbar_rr #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MASTER_COUNT   = 2,
  parameter int SLAVE_COUNT    = 4,
  parameter logic [SLAVE_COUNT-1:0][ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [SLAVE_COUNT-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst_n,
  input  logic [MASTER_COUNT-1:0]                  master_cyc,
  input  logic [MASTER_COUNT-1:0]                  master_stb,
  input  logic [MASTER_COUNT-1:0]                  master_we,
  input  logic [MASTER_COUNT-1:0][2:0]             master_tag,
  input  logic [MASTER_COUNT-1:0][DATA_WIDTH/8-1:0] master_sel,
  input  logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0]  master_adr,
  input  logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0]  master_mosi,
  output logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0]  master_miso,
  output logic [MASTER_COUNT-1:0]                  master_ack,
  output logic [MASTER_COUNT-1:0]                  master_err,
  output logic [SLAVE_COUNT-1:0]                   slave_cyc,
  output logic [SLAVE_COUNT-1:0]                   slave_stb,
  output logic [SLAVE_COUNT-1:0]                   slave_we,
  output logic [SLAVE_COUNT-1:0][2:0]              slave_tag,
  output logic [SLAVE_COUNT-1:0][DATA_WIDTH/8-1:0] slave_sel,
  output logic [SLAVE_COUNT-1:0][ADDR_WIDTH-1:0]   slave_adr,
  output logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0]   slave_mosi,
  input  logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0]   slave_miso,
  input  logic [SLAVE_COUNT-1:0]                   slave_ack,
  input  logic [SLAVE_COUNT-1:0]                   slave_err,
  output logic [SLAVE_COUNT-1:0]                   slave_busy,
  output logic [MASTER_COUNT-1:0]                  timeout_evt
);

  localparam int MW = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam int SW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t                  state     [MASTER_COUNT];
  logic [SW-1:0]           tgt       [MASTER_COUNT];
  logic [CW-1:0]           wd_cnt    [MASTER_COUNT];
  logic [MASTER_COUNT-1:0] timeout_q;

  logic [MW-1:0]           owner     [SLAVE_COUNT];
  logic [MW-1:0]           rr        [SLAVE_COUNT];
  logic [SLAVE_COUNT-1:0]  owner_valid;

  logic [MASTER_COUNT-1:0] dec_hit;
  logic [SW-1:0]           dec_idx   [MASTER_COUNT];
  logic [DATA_WIDTH-1:0]   tgt_miso  [MASTER_COUNT];
  logic [MASTER_COUNT-1:0] tgt_ack, tgt_err;
  logic [MASTER_COUNT-1:0] at_limit, retarget, fire, release_m;

  logic [MASTER_COUNT-1:0] grant_m;
  logic [SLAVE_COUNT-1:0]  grant_s;
  logic [MW-1:0]           grant_idx [SLAVE_COUNT];
  int                      cand;

  // Scan downwards so the lowest matching slave overrides any higher overlap.
  always_comb begin
    for (int m = 0; m < MASTER_COUNT; m++) begin
      dec_hit[m] = 1'b0;
      dec_idx[m] = '0;
      for (int s = SLAVE_COUNT - 1; s >= 0; s--) begin
        if (((master_adr[m] ^ SLAVE_ADDR[s]) & ~SLAVE_MASK[s]) == '0) begin
          dec_hit[m] = 1'b1;
          dec_idx[m] = SW'(s);
        end
      end
    end
  end

  // The stb/cyc blanking uses at_limit rather than fire so no path runs from slave_ack to slave_stb.
  always_comb begin
    for (int m = 0; m < MASTER_COUNT; m++) begin
      tgt_miso[m]  = slave_miso[tgt[m]];
      tgt_ack[m]   = slave_ack[tgt[m]];
      tgt_err[m]   = slave_err[tgt[m]];
      at_limit[m]  = (TIMEOUT_CYCLES != 0) && (state[m] == ST_ACTIVE) && master_cyc[m] &&
                     master_stb[m] && (wd_cnt[m] == CW'(TIMEOUT_CYCLES - 1));
      retarget[m]  = (state[m] == ST_ACTIVE) && master_cyc[m] && master_stb[m] &&
                     (!dec_hit[m] || (dec_idx[m] != tgt[m]));
      fire[m]      = at_limit[m] && !tgt_ack[m] && !tgt_err[m] && !retarget[m];
      release_m[m] = (state[m] == ST_ACTIVE) && (!master_cyc[m] || retarget[m] || fire[m]);
    end
  end

  always_comb begin
    grant_m = '0;
    cand    = 0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      grant_s[s]   = 1'b0;
      grant_idx[s] = '0;
      if (!owner_valid[s]) begin
        for (int k = 0; k < MASTER_COUNT; k++) begin
          cand = int'(rr[s]) + k;
          if (cand >= MASTER_COUNT) cand = cand - MASTER_COUNT;
          if (!grant_s[s] && (state[cand] == ST_WAIT) && master_cyc[cand] &&
              (int'(tgt[cand]) == s)) begin
            grant_s[s]    = 1'b1;
            grant_idx[s]  = MW'(cand);
            grant_m[cand] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int m = 0; m < MASTER_COUNT; m++) begin
        state[m]  <= ST_IDLE;
        tgt[m]    <= '0;
        wd_cnt[m] <= '0;
      end
      timeout_q <= '0;
    end else begin
      for (int m = 0; m < MASTER_COUNT; m++) begin
        timeout_q[m] <= 1'b0;
        case (state[m])
          ST_IDLE: begin
            if (master_cyc[m] && master_stb[m]) begin
              if (dec_hit[m]) begin
                state[m] <= ST_WAIT;
                tgt[m]   <= dec_idx[m];
              end else begin
                state[m] <= ST_ERR;
              end
            end
          end
          ST_WAIT: begin
            if (!master_cyc[m])  state[m] <= ST_IDLE;
            else if (grant_m[m]) state[m] <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (release_m[m]) begin
              state[m]     <= master_cyc[m] ? ST_ERR : ST_IDLE;
              wd_cnt[m]    <= '0;
              timeout_q[m] <= fire[m];
            end else if (tgt_ack[m] || tgt_err[m]) begin
              wd_cnt[m] <= '0;
            end else if (master_stb[m]) begin
              wd_cnt[m] <= wd_cnt[m] + 1'b1;
            end
          end
          default: state[m] <= ST_IDLE;
        endcase
      end
    end
  end

  // A slave is released and re-granted on different edges since grants only look at free slaves.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      owner_valid <= '0;
      for (int s = 0; s < SLAVE_COUNT; s++) begin
        owner[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < SLAVE_COUNT; s++) begin
        if (owner_valid[s]) begin
          if (release_m[owner[s]]) begin
            owner_valid[s] <= 1'b0;
            rr[s]          <= (int'(owner[s]) == MASTER_COUNT - 1) ? '0 : owner[s] + 1'b1;
          end
        end else if (grant_s[s]) begin
          owner_valid[s] <= 1'b1;
          owner[s]       <= grant_idx[s];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      slave_cyc[s]  = 1'b0;
      slave_stb[s]  = 1'b0;
      slave_we[s]   = 1'b0;
      slave_tag[s]  = '0;
      slave_sel[s]  = '0;
      slave_adr[s]  = '0;
      slave_mosi[s] = '0;
      if (owner_valid[s]) begin
        slave_cyc[s]  = master_cyc[owner[s]] & ~at_limit[owner[s]];
        slave_stb[s]  = master_stb[owner[s]] & ~at_limit[owner[s]];
        slave_we[s]   = master_we[owner[s]];
        slave_tag[s]  = master_tag[owner[s]];
        slave_sel[s]  = master_sel[owner[s]];
        slave_adr[s]  = master_adr[owner[s]];
        slave_mosi[s] = master_mosi[owner[s]];
      end
    end
    for (int m = 0; m < MASTER_COUNT; m++) begin
      master_miso[m] = '0;
      master_ack[m]  = 1'b0;
      master_err[m]  = (state[m] == ST_ERR);
      if (state[m] == ST_ACTIVE) begin
        master_miso[m] = tgt_miso[m];
        master_ack[m]  = tgt_ack[m];
        master_err[m]  = tgt_err[m];
      end
    end
  end

  assign slave_busy  = owner_valid;
  assign timeout_evt = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_crossbar_rr.sv
`default_nettype none
// tb_wb_crossbar_rr: random masters/slaves against a transaction-level crossbar model.  Rev 1.0
module tb_wb_crossbar_rr;

  localparam int M    = 2;
  localparam int S    = 4;
  localparam int TMO  = 8;
  localparam int NCYC = 3000;
  localparam logic [31:0] BASE [S] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000};
  localparam logic [31:0] MASK [S] = '{32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_7FFF};

  logic                 sys_clk, sys_rst_n;
  logic [M-1:0]         master_cyc, master_stb, master_we, master_ack, master_err, timeout_evt;
  logic [M-1:0][2:0]    master_tag;
  logic [M-1:0][3:0]    master_sel;
  logic [M-1:0][31:0]   master_adr, master_mosi, master_miso;
  logic [S-1:0]         slave_cyc, slave_stb, slave_we, slave_ack, slave_err, slave_busy;
  logic [S-1:0][2:0]    slave_tag;
  logic [S-1:0][3:0]    slave_sel;
  logic [S-1:0][31:0]   slave_adr, slave_mosi, slave_miso;

  wb_crossbar_rr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MASTER_COUNT(M), .SLAVE_COUNT(S),
    .SLAVE_ADDR({32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({32'h0000_7FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF}),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .master_cyc(master_cyc), .master_stb(master_stb), .master_we(master_we),
    .master_tag(master_tag), .master_sel(master_sel), .master_adr(master_adr),
    .master_mosi(master_mosi), .master_miso(master_miso),
    .master_ack(master_ack), .master_err(master_err),
    .slave_cyc(slave_cyc), .slave_stb(slave_stb), .slave_we(slave_we),
    .slave_tag(slave_tag), .slave_sel(slave_sel), .slave_adr(slave_adr),
    .slave_mosi(slave_mosi), .slave_miso(slave_miso),
    .slave_ack(slave_ack), .slave_err(slave_err),
    .slave_busy(slave_busy), .timeout_evt(timeout_evt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: who waits for which slave, who holds which slave, and pending error pulses.
  bit          queued [M];
  int          want   [M];
  int          owns   [M];
  bit          erring [M];
  int          stall  [M];
  bit          evt_q  [M];
  bit          lim    [M];
  int          holder [S];
  int          next_rr[S];

  logic [M-1:0]       e_ack, e_err, e_evt;
  logic [31:0]        e_miso [M];
  logic [S-1:0]       e_scyc, e_sstb, e_swe, e_busy;
  logic [2:0]         e_stag [S];
  logic [3:0]         e_ssel [S];
  logic [31:0]        e_sadr [S];
  logic [31:0]        e_smosi[S];

  int  ack_pct [S];
  int  err_pct;
  bit  narrow;

  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < S; s++)
      if (((a ^ BASE[s]) & ~MASK[s]) == 32'h0) return s;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      queued[m] = 0; want[m] = 0; owns[m] = -1; erring[m] = 0; stall[m] = 0; evt_q[m] = 0;
    end
    for (int s = 0; s < S; s++) begin
      holder[s] = -1; next_rr[s] = 0;
    end
  endtask

  task automatic model_eval();
    e_ack = '0; e_err = '0;
    for (int m = 0; m < M; m++) begin
      lim[m] = (owns[m] >= 0) && master_cyc[m] && master_stb[m] && (stall[m] == TMO - 1);
      e_evt[m]  = evt_q[m];
      e_miso[m] = 32'h0;
      if (owns[m] >= 0) begin
        e_miso[m] = slave_miso[owns[m]];
        e_ack[m]  = slave_ack[owns[m]];
        e_err[m]  = slave_err[owns[m]];
      end else begin
        e_err[m] = erring[m];
      end
    end
    for (int s = 0; s < S; s++) begin
      int h = holder[s];
      e_busy[s] = (h >= 0);
      e_scyc[s] = 0; e_sstb[s] = 0; e_swe[s] = 0;
      e_stag[s] = '0; e_ssel[s] = '0; e_sadr[s] = '0; e_smosi[s] = '0;
      if (h >= 0) begin
        e_scyc[s]  = master_cyc[h] && !lim[h];
        e_sstb[s]  = master_stb[h] && !lim[h];
        e_swe[s]   = master_we[h];
        e_stag[s]  = master_tag[h];
        e_ssel[s]  = master_sel[h];
        e_sadr[s]  = master_adr[h];
        e_smosi[s] = master_mosi[h];
      end
    end
  endtask

  task automatic let_go(input int m);
    holder[owns[m]]  = -1;
    next_rr[owns[m]] = (m + 1) % M;
    owns[m]  = -1;
    stall[m] = 0;
  endtask

  task automatic model_step();
    int gnt [S];
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    for (int s = 0; s < S; s++) begin
      gnt[s] = -1;
      if (holder[s] < 0)
        for (int k = 0; k < M; k++) begin
          int c = (next_rr[s] + k) % M;
          if (gnt[s] < 0 && queued[c] && master_cyc[c] && want[c] == s) gnt[s] = c;
        end
    end
    for (int m = 0; m < M; m++) begin
      int d = decode(master_adr[m]);
      evt_q[m] = 0;
      if (erring[m]) begin
        erring[m] = 0;
      end else if (queued[m]) begin
        if (!master_cyc[m]) queued[m] = 0;
        else if (gnt[want[m]] == m) begin
          queued[m] = 0;
          owns[m]   = want[m];
        end
      end else if (owns[m] >= 0) begin
        bit term = slave_ack[owns[m]] || slave_err[owns[m]];
        if (!master_cyc[m]) let_go(m);
        else if (master_stb[m] && d != owns[m]) begin
          let_go(m); erring[m] = 1;
        end else if (lim[m] && !term) begin
          let_go(m); erring[m] = 1; evt_q[m] = 1;
        end else begin
          stall[m] = term ? 0 : stall[m] + (master_stb[m] ? 1 : 0);
        end
      end else if (master_cyc[m] && master_stb[m]) begin
        if (d < 0) erring[m] = 1;
        else begin
          queued[m] = 1; want[m] = d;
        end
      end
    end
    for (int s = 0; s < S; s++)
      if (gnt[s] >= 0) holder[s] = gnt[s];
  endtask

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 9);
    int s = narrow ? ((r < 6) ? 0 : 2) : (r % 4);
    logic [31:0] off = $urandom & 32'h0000_0FFC;
    if (!narrow && r == 0) return 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
    case (s)
      0:       return off;
      1:       return 32'h0000_1000 | off;
      2:       return 32'h0000_2000 | off;
      default: return 32'h0000_4000 | ($urandom & 32'h0000_3FFC);
    endcase
  endfunction

  task automatic new_strobe(input int m, input bit anywhere);
    master_cyc[m]  = 1'b1;
    master_stb[m]  = 1'b1;
    master_we[m]   = 1'($urandom);
    master_tag[m]  = 3'($urandom);
    master_sel[m]  = 4'($urandom);
    master_mosi[m] = $urandom;
    if (anywhere || master_adr[m] == 32'h0) master_adr[m] = pick_addr();
    else master_adr[m] = (master_adr[m] & ~32'h0000_0FFF) | ($urandom & 32'h0000_0FFC);
  endtask

  task automatic drive(input int n);
    sys_rst_n = !(n < 2 || n == 900 || n == 1850);
    if (n < 1000) begin
      for (int s = 0; s < S; s++) ack_pct[s] = 50;
      err_pct = 0; narrow = 0;
    end else if (n < 2000) begin
      ack_pct = '{60, 40, 15, 0};
      err_pct = 3; narrow = 0;
    end else begin
      for (int s = 0; s < S; s++) ack_pct[s] = 35;
      err_pct = 5; narrow = 1;
    end
    for (int m = 0; m < M; m++) begin
      if (!master_cyc[m]) begin
        if ($urandom_range(0, 2) == 0) new_strobe(m, 1'b1);
      end else if (e_ack[m] || e_err[m]) begin
        if ($urandom_range(0, 1) == 0) begin
          master_cyc[m] = 1'b0; master_stb[m] = 1'b0;
        end else begin
          new_strobe(m, $urandom_range(0, 7) == 0);
        end
      end else if ($urandom_range(0, 31) == 0) begin
        master_cyc[m] = 1'b0; master_stb[m] = 1'b0;
      end else begin
        master_stb[m] = ($urandom_range(0, 7) != 0);
      end
    end
    // Slaves answer one cycle after they saw a strobe; e_sstb still holds last cycle's value.
    for (int s = 0; s < S; s++) begin
      slave_miso[s] = $urandom;
      slave_ack[s]  = 1'b0;
      slave_err[s]  = 1'b0;
      if (e_sstb[s]) begin
        if ($urandom_range(0, 99) < ack_pct[s])      slave_ack[s] = 1'b1;
        else if ($urandom_range(0, 99) < err_pct)    slave_err[s] = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("m_ack", 64'(master_ack), 64'(e_ack));
    check("m_err", 64'(master_err), 64'(e_err));
    check("tmo_evt", 64'(timeout_evt), 64'(e_evt));
    check("s_cyc", 64'(slave_cyc), 64'(e_scyc));
    check("s_stb", 64'(slave_stb), 64'(e_sstb));
    check("s_we", 64'(slave_we), 64'(e_swe));
    check("s_busy", 64'(slave_busy), 64'(e_busy));
    for (int m = 0; m < M; m++)
      check($sformatf("m%0d_miso", m), 64'(master_miso[m]), 64'(e_miso[m]));
    for (int s = 0; s < S; s++) begin
      check($sformatf("s%0d_adr", s), 64'(slave_adr[s]), 64'(e_sadr[s]));
      check($sformatf("s%0d_mosi", s), 64'(slave_mosi[s]), 64'(e_smosi[s]));
      check($sformatf("s%0d_tagsel", s), 64'({slave_tag[s], slave_sel[s]}),
            64'({e_stag[s], e_ssel[s]}));
    end
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    master_cyc  = '0; master_stb = '0; master_we = '0; master_tag = '0;
    master_sel  = '0; master_adr = '0; master_mosi = '0;
    slave_miso  = '0; slave_ack = '0; slave_err = '0;
    e_ack = '0; e_err = '0; e_sstb = '0;
    model_reset();
    for (int n = 0; n < NCYC; n++) begin
      @(posedge sys_clk);
      #1;
      drive(n);
      @(negedge sys_clk);
      model_eval();
      compare();
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
